// File: rtl/id_ex_stage.sv
// MIPS decode stage and ID/EX pipeline register: splits the IF/ID word, bypasses
// a same-cycle WB write, detects load-use hazards and inserts bubbles on stall/flush.
module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [31:0]      id_instr,
    input  logic [31:0]      id_pc4,
    output logic [4:0]       readReg1,
    output logic [4:0]       readReg2,
    input  logic [31:0]      readData1,
    input  logic [31:0]      readData2,
    input  logic             wb_regWrite,
    input  logic [4:0]       wb_writeReg,
    input  logic [31:0]      wb_writeData,
    input  logic             ex_flush,
    output logic             stall,
    output logic             ex_valid,
    output logic [31:0]      ex_pc4,
    output logic [31:0]      ex_opA,
    output logic [31:0]      ex_opB,
    output logic [31:0]      ex_imm,
    output logic [4:0]       ex_rs,
    output logic [4:0]       ex_rt,
    output logic [4:0]       ex_wreg,
    output logic [5:0]       ex_opcode,
    output logic [5:0]       ex_funct,
    output logic [4:0]       ex_shamt,
    output logic             ex_regWrite,
    output logic             ex_memRead,
    output logic             ex_memWrite,
    output logic [CNT_W-1:0] stall_count
);

    typedef struct packed {
        logic        valid;
        logic [31:0] pc4;
        logic [31:0] opA;
        logic [31:0] opB;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wreg;
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  shamt;
        logic        regWrite;
        logic        memRead;
        logic        memWrite;
    } idex_t;

    idex_t            ex_q, ex_d, dec;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;
    logic        uses_rt;

    assign opcode   = id_instr[31:26];
    assign rs       = id_instr[25:21];
    assign rt       = id_instr[20:16];
    assign rd       = id_instr[15:11];
    assign imm16    = id_instr[15:0];
    assign readReg1 = rs;
    assign readReg2 = rt;

    assign uses_rt = (opcode == 6'h00) || (opcode == 6'h2B) ||
                     (opcode == 6'h04) || (opcode == 6'h05);

    // Register file writes on the edge, so a same-cycle WB write must be forwarded here.
    function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] rdata,
                                            input logic wen, input logic [4:0] wreg,
                                            input logic [31:0] wdata);
        if (r == 5'd0)               return 32'd0;
        else if (wen && wreg == r)   return wdata;
        else                         return rdata;
    endfunction

    always_comb begin
        dec        = '0;
        dec.valid  = id_valid;
        dec.pc4    = id_pc4;
        dec.opA    = operand(rs, readData1, wb_regWrite, wb_writeReg, wb_writeData);
        dec.opB    = operand(rt, readData2, wb_regWrite, wb_writeReg, wb_writeData);
        dec.rs     = rs;
        dec.rt     = rt;
        dec.opcode = opcode;
        dec.funct  = id_instr[5:0];
        dec.shamt  = id_instr[10:6];

        case (opcode)
            6'h0C, 6'h0D: dec.imm = {16'h0000, imm16};
            6'h0F:        dec.imm = {imm16, 16'h0000};
            default:      dec.imm = {{16{imm16[15]}}, imm16};
        endcase

        case (opcode)
            6'h00:   dec.wreg = rd;
            6'h03:   dec.wreg = 5'd31;
            default: dec.wreg = rt;
        endcase

        case (opcode)
            6'h00, 6'h03, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23: dec.regWrite = id_valid;
            default:                                                dec.regWrite = 1'b0;
        endcase
        dec.memRead  = id_valid && (opcode == 6'h23);
        dec.memWrite = id_valid && (opcode == 6'h2B);
    end

    assign stall = id_valid && ex_q.valid && ex_q.memRead && (ex_q.wreg != 5'd0) &&
                   ((ex_q.wreg == rs) || (uses_rt && ex_q.wreg == rt)) && !ex_flush;

    // A bubble only needs its valid/control bits cleared; data fields are don't-care.
    always_comb begin
        ex_d  = dec;
        cnt_d = cnt_q;
        if (ex_flush || stall) begin
            ex_d.valid    = 1'b0;
            ex_d.regWrite = 1'b0;
            ex_d.memRead  = 1'b0;
            ex_d.memWrite = 1'b0;
        end
        if (stall && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign ex_valid    = ex_q.valid;
    assign ex_pc4      = ex_q.pc4;
    assign ex_opA      = ex_q.opA;
    assign ex_opB      = ex_q.opB;
    assign ex_imm      = ex_q.imm;
    assign ex_rs       = ex_q.rs;
    assign ex_rt       = ex_q.rt;
    assign ex_wreg     = ex_q.wreg;
    assign ex_opcode   = ex_q.opcode;
    assign ex_funct    = ex_q.funct;
    assign ex_shamt    = ex_q.shamt;
    assign ex_regWrite = ex_q.regWrite;
    assign ex_memRead  = ex_q.memRead;
    assign ex_memWrite = ex_q.memWrite;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed literal cases plus randomized traffic checked every
// cycle against a behavioural model of the ID/EX register.
module tb_id_ex_stage;

    logic        clock_in = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_instr, id_pc4, readData1, readData2, wb_writeData;
    logic        wb_regWrite, ex_flush;
    logic [4:0]  wb_writeReg;

    logic [4:0]  readReg1, readReg2, ex_rs, ex_rt, ex_wreg, ex_shamt;
    logic        stall, ex_valid, ex_regWrite, ex_memRead, ex_memWrite;
    logic [31:0] ex_pc4, ex_opA, ex_opB, ex_imm;
    logic [5:0]  ex_opcode, ex_funct;
    logic [15:0] stall_count;

    // Narrow-counter copy so saturation is reachable in a short run.
    logic [4:0]  s_readReg1, s_readReg2, s_rs, s_rt, s_wreg, s_shamt;
    logic        s_stall, s_valid, s_regWrite, s_memRead, s_memWrite;
    logic [31:0] s_pc4, s_opA, s_opB, s_imm;
    logic [5:0]  s_opcode, s_funct;
    logic [1:0]  s_count;

    always #5 clock_in = ~clock_in;

    id_ex_stage #(.CNT_W(16)) dut (
        .clock_in(clock_in), .reset(reset), .id_valid(id_valid), .id_instr(id_instr),
        .id_pc4(id_pc4), .readReg1(readReg1), .readReg2(readReg2),
        .readData1(readData1), .readData2(readData2), .wb_regWrite(wb_regWrite),
        .wb_writeReg(wb_writeReg), .wb_writeData(wb_writeData), .ex_flush(ex_flush),
        .stall(stall), .ex_valid(ex_valid), .ex_pc4(ex_pc4), .ex_opA(ex_opA),
        .ex_opB(ex_opB), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wreg(ex_wreg),
        .ex_opcode(ex_opcode), .ex_funct(ex_funct), .ex_shamt(ex_shamt),
        .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
        .stall_count(stall_count)
    );

    id_ex_stage #(.CNT_W(2)) dut_s (
        .clock_in(clock_in), .reset(reset), .id_valid(id_valid), .id_instr(id_instr),
        .id_pc4(id_pc4), .readReg1(s_readReg1), .readReg2(s_readReg2),
        .readData1(readData1), .readData2(readData2), .wb_regWrite(wb_regWrite),
        .wb_writeReg(wb_writeReg), .wb_writeData(wb_writeData), .ex_flush(ex_flush),
        .stall(s_stall), .ex_valid(s_valid), .ex_pc4(s_pc4), .ex_opA(s_opA),
        .ex_opB(s_opB), .ex_imm(s_imm), .ex_rs(s_rs), .ex_rt(s_rt), .ex_wreg(s_wreg),
        .ex_opcode(s_opcode), .ex_funct(s_funct), .ex_shamt(s_shamt),
        .ex_regWrite(s_regWrite), .ex_memRead(s_memRead), .ex_memWrite(s_memWrite),
        .stall_count(s_count)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model of what ID/EX must hold.
    logic        m_valid = 0, m_rw = 0, m_mr = 0, m_mw = 0;
    logic [31:0] m_pc4 = 0, m_opA = 0, m_opB = 0, m_imm = 0, m_instr = 0;
    logic [4:0]  m_wreg = 0;
    int          m_cnt = 0;
    bit          m_stall;

    function automatic logic [31:0] f_imm(input logic [31:0] ins);
        logic [5:0]  op = ins[31:26];
        logic [15:0] i  = ins[15:0];
        if (op == 6'h0C || op == 6'h0D) return {16'h0, i};
        if (op == 6'h0F)                return {i, 16'h0};
        return {{16{i[15]}}, i};
    endfunction

    function automatic logic [4:0] f_wreg(input logic [31:0] ins);
        if (ins[31:26] == 6'h00) return ins[15:11];
        if (ins[31:26] == 6'h03) return 5'd31;
        return ins[20:16];
    endfunction

    function automatic logic [31:0] f_op(input logic [4:0] r, input logic [31:0] rdat);
        if (r == 0) return 0;
        if (wb_regWrite && wb_writeReg == r) return wb_writeData;
        return rdat;
    endfunction

    function automatic bit f_hazard();
        logic [5:0] op = id_instr[31:26];
        bit urt = (op inside {6'h00, 6'h2B, 6'h04, 6'h05});
        return id_valid && m_valid && m_mr && m_wreg != 0 && !ex_flush &&
               (m_wreg == id_instr[25:21] || (urt && m_wreg == id_instr[20:16]));
    endfunction

    // One clock: check the combinational stall, advance the model across the edge,
    // then compare registered outputs on the falling edge.
    task automatic tick();
        logic [5:0]  op;
        logic        nv, nrw, nmr, nmw;
        logic [31:0] na, nb;
        #1;
        m_stall = f_hazard();
        chk("stall", stall, m_stall);
        chk("stall_s", s_stall, m_stall);
        chk("readReg1", readReg1, id_instr[25:21]);
        chk("readReg2", readReg2, id_instr[20:16]);
        op  = id_instr[31:26];
        nv  = id_valid && !ex_flush && !m_stall;
        nrw = nv && (op inside {6'h00, 6'h03, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23});
        nmr = nv && op == 6'h23;
        nmw = nv && op == 6'h2B;
        na  = f_op(id_instr[25:21], readData1);
        nb  = f_op(id_instr[20:16], readData2);
        @(posedge clock_in);
        if (!reset) begin
            m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_cnt = 0;
            m_pc4 = 0; m_opA = 0; m_opB = 0; m_imm = 0; m_instr = 0; m_wreg = 0;
        end else begin
            m_valid = nv; m_rw = nrw; m_mr = nmr; m_mw = nmw;
            m_pc4 = id_pc4; m_opA = na; m_opB = nb; m_instr = id_instr;
            m_imm = f_imm(id_instr); m_wreg = f_wreg(id_instr);
            if (m_stall && m_cnt < 65535) m_cnt++;
        end
        @(negedge clock_in);
        chk("ex_valid", ex_valid, m_valid);
        chk("ex_regWrite", ex_regWrite, m_rw);
        chk("ex_memRead", ex_memRead, m_mr);
        chk("ex_memWrite", ex_memWrite, m_mw);
        chk("stall_count", stall_count, m_cnt);
        chk("stall_count_sat", s_count, (m_cnt > 3) ? 3 : m_cnt);
        chk("s_valid", s_valid, m_valid);
        if (m_valid) begin
            chk("ex_pc4", ex_pc4, m_pc4);
            chk("ex_opA", ex_opA, m_opA);
            chk("ex_opB", ex_opB, m_opB);
            chk("ex_imm", ex_imm, m_imm);
            chk("ex_rs", ex_rs, m_instr[25:21]);
            chk("ex_rt", ex_rt, m_instr[20:16]);
            chk("ex_wreg", ex_wreg, m_wreg);
            chk("ex_opcode", ex_opcode, m_instr[31:26]);
            chk("ex_funct", ex_funct, m_instr[5:0]);
            chk("ex_shamt", ex_shamt, m_instr[10:6]);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] r1,
                         input logic [31:0] r2, input logic fl);
        id_valid = v; id_instr = ins; readData1 = r1; readData2 = r2; ex_flush = fl;
        id_pc4 = $urandom;
    endtask

    task automatic wb(input logic w, input logic [4:0] r, input logic [31:0] d);
        wb_regWrite = w; wb_writeReg = r; wb_writeData = d;
    endtask

    logic [5:0] ops [12] = '{6'h00, 6'h03, 6'h08, 6'h0A, 6'h0C, 6'h0D,
                             6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h3F};

    initial begin
        // T1: reset held with random inputs
        reset = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, $urandom, $urandom, $urandom, 1'($urandom));
            wb(1'($urandom), 5'($urandom), $urandom);
            tick();
            chk("rst_ex_valid", ex_valid, 0);
            chk("rst_ex_opA", ex_opA, 0);
            chk("rst_ex_imm", ex_imm, 0);
            chk("rst_ex_wreg", ex_wreg, 0);
            chk("rst_stall", stall, 0);
            chk("rst_count", stall_count, 0);
        end
        reset = 1;
        wb(0, 0, 0);
        drive(1, 32'h00221820, 5, 7, 0);
        tick();
        chk("T1_opA", ex_opA, 5);
        chk("T1_opB", ex_opB, 7);
        chk("T1_wreg", ex_wreg, 3);
        chk("T1_regWrite", ex_regWrite, 1);

        // T2: WB bypass
        wb(1, 1, 32'hFFFFFFFF);
        drive(1, 32'h00221820, 0, 9, 0);
        tick();
        chk("T2_bypass", ex_opA, 32'hFFFFFFFF);

        // T3: $0 always reads zero
        wb(1, 0, 32'hFFFFFFFF);
        drive(1, 32'h00001820, 32'h1234, 32'h5678, 0);
        tick();
        chk("T3_opA", ex_opA, 0);
        chk("T3_opB", ex_opB, 0);

        // T4: load-use stall
        wb(0, 0, 0);
        drive(1, 32'h8C220000, 1, 2, 0);
        tick();
        drive(1, 32'h00441820, 3, 4, 0);
        #1 chk("T4_stall", stall, 1);
        tick();
        chk("T4_bubble", ex_valid, 0);
        tick();
        chk("T4_issue", ex_valid, 1);
        chk("T4_rs", ex_rs, 2);
        chk("T4_count", stall_count, 1);

        // T5: flush beats stall
        drive(1, 32'h8C220000, 1, 2, 0);
        tick();
        drive(1, 32'h00441820, 3, 4, 1);
        #1 chk("T5_stall", stall, 0);
        tick();
        chk("T5_bubble", ex_valid, 0);
        chk("T5_count", stall_count, 1);

        // T6: immediates
        ex_flush = 0;
        drive(1, 32'h2001FFFF, 0, 0, 0); tick(); chk("T6_addi", ex_imm, 32'hFFFFFFFF);
        drive(1, 32'h3001FFFF, 0, 0, 0); tick(); chk("T6_andi", ex_imm, 32'h0000FFFF);
        drive(1, 32'h3C01ABCD, 0, 0, 0); tick(); chk("T6_lui", ex_imm, 32'hABCD0000);

        // Randomized traffic; IF/ID holds its word while stalled, like the real pipe.
        for (int i = 0; i < 600; i++) begin
            if (!m_stall) begin
                id_valid = ($urandom_range(0, 9) != 0);
                id_instr = {ops[$urandom_range(0, 11)], 2'b0, 3'($urandom_range(0, 3)),
                            2'b0, 3'($urandom_range(0, 3)), 2'b0, 3'($urandom_range(0, 3)),
                            11'($urandom)};
                id_pc4 = $urandom;
            end
            readData1 = $urandom; readData2 = $urandom;
            ex_flush = ($urandom_range(0, 9) == 0);
            wb(1'($urandom), 5'($urandom_range(0, 3)), $urandom);
            if (i == 300) reset = 0;
            if (i == 302) reset = 1;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
